window_line_buffer: RTL and testbench
=====================================

# window_line_buffer

Streaming 3x3 window generator for the convolution datapath. Consumes the registered raster pixel stream (data + valid, one pixel per valid cycle, no backpressure) produced by the input data register stage. Holds the two previous image rows in on-chip line buffers and emits a flattened 3x3 neighbourhood each time a pixel completes a full window. Its output feeds the MAC/convolution stage directly.

## Interface
- dataWidth, 8, pixel width in bits
- IMG_WIDTH, 512, pixels per row; must be >= 3
- IMG_HEIGHT, 512, rows per frame; must be >= 3

- i_clk  in  1  sole clock; all state updates on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_data  in  dataWidth  raster pixel, row-major, top-left first
- i_data_valid  in  1  pixel accepted on every rising edge where high; no ready
- o_data  out  9*dataWidth  window; slot k = 3*i+j at [k*dataWidth +: dataWidth], i = row (0 = r-2, 2 = r), j = column (0 = c-2, 2 = c)
- o_data_valid  out  1  window valid strobe
- o_frame_done  out  1  present only with LB_FRAME_DONE_EN; see Configuration

## Operation
- Counters: col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1), widths $clog2 of their limits; they advance only on accepted pixels. col wraps at IMG_WIDTH-1 and increments row; row wraps at IMG_HEIGHT-1, starting the next frame at (0,0) with no idle cycle required.
- Line buffers: lb0 holds row r-2 and lb1 holds row r-1, each a register array of IMG_WIDTH x dataWidth, indexed by col, read asynchronously. On accepted pixel at col c: lb0[c] <= lb1[c]; lb1[c] <= i_data.
- Window registers: three 3-deep shift rows. On each accepted pixel, every row shifts one column toward j=0; the new j=2 column is {lb0[c], lb1[c], i_data} for i = 0, 1, 2.
- FSM with two states:
  - S_FILL (reset state): rows 0-1; no windows are produced. Moves to S_RUN on the accepted pixel (row 1, col IMG_WIDTH-1).
  - S_RUN: o_data_valid is asserted for each accepted pixel with col >= 2. Moves to S_FILL on the accepted pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- Windows never straddle rows. Columns 0-1 of every row shift in without a valid strobe, so stale left-edge columns are flushed before col 2.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Valid gaps: when i_data_valid is low, nothing advances. o_data holds its value and o_data_valid is 0.
- Reset (including mid-frame): col, row, o_data, the window registers and o_data_valid clear to 0; the FSM returns to S_FILL; o_frame_done clears to 0. Line buffer contents are not cleared, since S_FILL overwrites them before use. The first window after reset comes from the new stream's pixel (2,2).

## Timing
- Latency: 1 cycle. A pixel accepted at edge N produces o_data/o_data_valid visible after edge N, sampled at edge N+1.
- o_data_valid is a one-cycle strobe per window and can be high on consecutive cycles at full rate.
- Throughput: one pixel per cycle sustained, indefinitely, across frame boundaries.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- LB_FRAME_DONE_EN defined:
  - o_frame_done exists. It is registered and pulses high for exactly one cycle, coincident with the o_data_valid of the window whose current pixel is (IMG_HEIGHT-1, IMG_WIDTH-1).
  - Reset value 0.
- LB_FRAME_DONE_EN undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

## Test plan
(IMG_WIDTH=5, IMG_HEIGHT=4; pixel value = 10*row + col.)
- Continuous single frame -> exactly 6 windows. First window, after pixel 22, is slots k0..k8 = 0,1,2,10,11,12,20,21,22. Last window is 12,13,14,22,23,24,32,33,34.
- Random 0-3 cycle valid gaps inside the frame -> same 6 windows in the same order. o_data holds during gaps; o_data_valid is never high without a preceding accepted pixel.
- Two back-to-back frames, no idle cycle -> 12 windows. No window forms during rows 0-1 of frame 2. Frame 2's first window equals frame 1's first window.
- Assert i_rst asynchronously mid-row 2, then restart the frame -> all outputs are 0 immediately on reset. Exactly 6 correct windows follow, with no stale data.
- With LB_FRAME_DONE_EN -> o_frame_done is high for exactly one cycle, aligned with the window whose k8 = 34, once per frame. Without the macro, the build has no o_frame_done port.

Source files
------------

// File: rtl/window_line_buffer.sv
// Streaming 3x3 window generator: two row line buffers feed a 3x3 shift window.
// Optional LB_FRAME_DONE_EN adds a registered o_frame_done pulse on the frame's last window.
module window_line_buffer #(
  parameter int dataWidth  = 8,
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [dataWidth-1:0]   i_data,
  input  logic                   i_data_valid,
  output logic [9*dataWidth-1:0] o_data,
  output logic                   o_data_valid
`ifdef LB_FRAME_DONE_EN
  ,
  output logic                   o_frame_done
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [CW-1:0]        r_col;
  logic [RW-1:0]        r_row;
  logic [dataWidth-1:0] r_lb0 [IMG_WIDTH];
  logic [dataWidth-1:0] r_lb1 [IMG_WIDTH];
  logic [dataWidth-1:0] r_win [3][3];
  logic [dataWidth-1:0] w_new_col [3];
  logic                 r_valid;
  logic                 w_col_last;
  logic                 w_row_last;
  logic                 w_win_fire;

  // Next-state and window-fire decode; every output of this block is registered below.
  always_comb begin
    w_next_state = r_state;
    w_col_last   = (r_col == COL_LAST);
    w_row_last   = (r_row == ROW_LAST);
    w_win_fire   = 1'b0;
    case (r_state)
      S_FILL: begin
        if (i_data_valid && w_col_last && (r_row == RW'(1)))
          w_next_state = S_RUN;
      end
      S_RUN: begin
        w_win_fire = i_data_valid && (r_col >= CW'(2));
        if (i_data_valid && w_col_last && w_row_last)
          w_next_state = S_FILL;
      end
      default: w_next_state = S_FILL;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_FILL;
    else       r_state <= w_next_state;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_data_valid) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // NOTE: line buffers are deliberately not reset; fill rows overwrite them before any window uses them.
  always_ff @(posedge i_clk) begin
    if (i_data_valid) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= i_data;
    end
  end

  always_comb begin
    w_new_col[0] = r_lb0[r_col];
    w_new_col[1] = r_lb1[r_col];
    w_new_col[2] = i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          r_win[i][j] <= '0;
    end else if (i_data_valid) begin
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
        r_win[i][2] <= w_new_col[i];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_valid <= 1'b0;
    else       r_valid <= w_win_fire;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_col
      assign o_data[(3*gi+gj)*dataWidth +: dataWidth] = r_win[gi][gj];
    end
  end

  assign o_data_valid = r_valid;

`ifdef LB_FRAME_DONE_EN
  logic r_frame_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_frame_done <= 1'b0;
    else       r_frame_done <= w_win_fire && w_col_last && w_row_last;
  end

  assign o_frame_done = r_frame_done;
`endif

endmodule

// File: tb/tb_window_line_buffer.sv
// Directed bench for window_line_buffer at 5x4; pixel value = 10*row + col.
// Covers reset, continuous and back-to-back frames, valid gaps and mid-frame async reset.
module tb_window_line_buffer;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data;
  logic          dv;
  logic [9*DW-1:0] odata;
  logic          ovalid;
`ifdef LB_FRAME_DONE_EN
  logic          ofd;
`endif

  int          total = 0;
  int          bad   = 0;
  int          nwin;
  logic [71:0] held;
  bit          held_ok;
  bit          got_first;
  logic [71:0] first_obs;
  logic [71:0] last_obs;
  logic [71:0] first_f1;

  localparam logic [71:0] FIRST_WIN = 72'h16_15_14_0C_0B_0A_02_01_00;
  localparam logic [71:0] LAST_WIN  = 72'h22_21_20_18_17_16_0E_0D_0C;

  window_line_buffer #(.dataWidth(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data       (data),
    .i_data_valid (dv),
    .o_data       (odata),
    .o_data_valid (ovalid)
`ifdef LB_FRAME_DONE_EN
    ,
    .o_frame_done (ofd)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [71:0] win(int r, int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*8 +: 8] = 8'(10*(r-2+i) + (c-2+j));
    return w;
  endfunction

  task automatic check(string tag, logic [71:0] obs, logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    dv   = 1'b0;
    data = 8'($urandom);
    @(posedge clk);
    #1;
    check("gap_valid", 72'(ovalid), 72'd0);
    if (held_ok) check("gap_hold", odata, held);
`ifdef LB_FRAME_DONE_EN
    check("gap_frame_done", 72'(ofd), 72'd0);
`endif
  endtask

  task automatic pix(int r, int c);
    bit w;
    @(negedge clk);
    dv   = 1'b1;
    data = 8'(10*r + c);
    @(posedge clk);
    #1;
    w = (r >= 2) && (c >= 2);
    check("valid", 72'(ovalid), 72'(w));
    if (ovalid === 1'b1) begin
      if (!got_first) first_obs = odata;
      got_first = 1'b1;
      last_obs  = odata;
    end
    if (w) begin
      check("window", odata, win(r, c));
      held    = win(r, c);
      held_ok = 1'b1;
      nwin++;
    end else begin
      held_ok = 1'b0;
    end
`ifdef LB_FRAME_DONE_EN
    check("frame_done", 72'(ofd), 72'(w && r == H-1 && c == W-1));
`endif
  endtask

  task automatic frame(bit gaps);
    got_first = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        pix(r, c);
        if (gaps) repeat ($urandom_range(0, 3)) idle();
      end
  endtask

  initial begin
    rst     = 1'b1;
    dv      = 1'b0;
    data    = '0;
    held    = '0;
    held_ok = 1'b1;
    nwin    = 0;
    #1;
    check("reset_data", odata, 72'd0);
    check("reset_valid", 72'(ovalid), 72'd0);
`ifdef LB_FRAME_DONE_EN
    check("reset_frame_done", 72'(ofd), 72'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // Continuous frame, then a second frame with no idle cycle between them.
    frame(1'b0);
    check("f1_count", 72'(nwin), 72'd6);
    check("f1_first", first_obs, FIRST_WIN);
    check("f1_last", last_obs, LAST_WIN);
    first_f1 = first_obs;
    frame(1'b0);
    check("f2_count", 72'(nwin), 72'd12);
    check("f2_first", first_obs, FIRST_WIN);
    check("f2_first_eq_f1", first_obs, first_f1);
    check("f2_last", last_obs, LAST_WIN);
    idle();
    idle();

    // Frame with random 0-3 cycle gaps after every pixel.
    nwin = 0;
    frame(1'b1);
    check("gap_count", 72'(nwin), 72'd6);
    check("gap_first", first_obs, FIRST_WIN);
    check("gap_last", last_obs, LAST_WIN);
    idle();

    // Partial frame into row 2, asynchronous reset away from any clock edge, then restart.
    got_first = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) pix(r, c);
    for (int c = 0; c < 4; c++) pix(2, c);
    @(negedge clk);
    dv = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_data", odata, 72'd0);
    check("async_rst_valid", 72'(ovalid), 72'd0);
`ifdef LB_FRAME_DONE_EN
    check("async_rst_frame_done", 72'(ofd), 72'd0);
`endif
    @(negedge clk);
    rst     = 1'b0;
    held    = '0;
    held_ok = 1'b1;
    idle();
    nwin = 0;
    frame(1'b0);
    check("rst_count", 72'(nwin), 72'd6);
    check("rst_first", first_obs, FIRST_WIN);
    check("rst_last", last_obs, LAST_WIN);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
